// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the packet write arbiter.
//   arb_state_e : packet FSM state (IDLE arbitrates, XFER streams one packet)
//   MAX_PORTS   : widest port vector the search helper handles
//   rr_pick()   : first set bit of a mask at or after a start index, wrapping
package wrr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int MAX_PORTS = 32;
  localparam int IDX_W     = 5;

  // Round-robin search over the first num_ports bits of mask. The start
  // index is always below num_ports, so a single subtraction wraps it. An
  // empty mask returns 0; callers qualify the result with their own "any"
  // flag.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] mask,
                                                input logic [IDX_W-1:0]     start,
                                                input int                   num_ports);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = int'(start) + k;
      if (idx >= num_ports) idx = idx - num_ports;
      if (!found && (k < num_ports) && mask[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wrr_arb_grant.sv
// Grant selection for the packet write arbiter.
// Picks a winner among requesting ports under strict priority (lowest index)
// or weighted round robin, and owns the per-port credit counters and the
// last-granted pointer. Only updates state while arb_en is high.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   arb_en     : top FSM is in IDLE and may take a grant this cycle
//   sp0_wrr1   : 0 = strict priority, 1 = weighted round robin
//   weight_p   : packed per-port weights (0 behaves as 1)
//   req        : per-port packet-start requests
//   gnt_valid  : a winner exists and arbitration is enabled
//   gnt_idx    : index of the winner
module wrr_arb_grant
  import wrr_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 16,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arb_en,
  input  logic                              sp0_wrr1,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
  input  logic [NUM_PORTS-1:0]              req,
  output logic                              gnt_valid,
  output logic [PORT_ID_WIDTH-1:0]          gnt_idx
);

  logic [WEIGHT_WIDTH-1:0]  credit_q [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0]  credit_d [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0]  weight_eff [NUM_PORTS];
  logic [WEIGHT_WIDTH-1:0]  credit_cur [NUM_PORTS];
  logic [PORT_ID_WIDTH-1:0] last_gnt_q, last_gnt_d;
  logic [PORT_ID_WIDTH-1:0] start_idx;
  logic                     load_pending_q, load_pending_d;
  logic [NUM_PORTS-1:0]     eligible;
  logic [NUM_PORTS-1:0]     pick_mask;
  logic                     reload;

  // Credits in use this cycle: right after reset they come straight from the
  // weights so the very first arbitration already sees loaded credits. A
  // requester with no credit left is not eligible; if nobody is eligible the
  // reloaded credits are used immediately so no bubble cycle is inserted.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      weight_eff[i] = (weight_p[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                      ? WEIGHT_WIDTH'(1) : weight_p[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      credit_cur[i] = load_pending_q ? weight_eff[i] : credit_q[i];
      eligible[i]   = req[i] && (credit_cur[i] != '0);
    end
    reload    = (|req) && !(|eligible);
    pick_mask = reload ? req : eligible;
    start_idx = (last_gnt_q == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : last_gnt_q + 1'b1;

    gnt_valid = arb_en && (|req);
    if (sp0_wrr1) begin
      gnt_idx = PORT_ID_WIDTH'(rr_pick(MAX_PORTS'(pick_mask), IDX_W'(start_idx), NUM_PORTS));
    end else begin
      gnt_idx = PORT_ID_WIDTH'(rr_pick(MAX_PORTS'(req), '0, NUM_PORTS));
    end
  end

  // Credit and pointer bookkeeping. Strict-priority grants leave credits and
  // the pointer untouched so a later switch back to WRR resumes where it was.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_d[i] = credit_cur[i];
    end
    last_gnt_d     = last_gnt_q;
    load_pending_d = 1'b0;
    if (gnt_valid && sp0_wrr1) begin
      if (reload) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          credit_d[i] = weight_eff[i];
        end
        credit_d[gnt_idx] = weight_eff[gnt_idx] - 1'b1;
      end else begin
        credit_d[gnt_idx] = credit_cur[gnt_idx] - 1'b1;
      end
      last_gnt_d = gnt_idx;
    end
  end

  // Reset parks the pointer on the last port so port 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit_q[i] <= '0;
      end
      last_gnt_q     <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      load_pending_q <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
      end
      last_gnt_q     <= last_gnt_d;
      load_pending_q <= load_pending_d;
    end
  end

endmodule

// File: rtl/wrr_pkt_write_arbiter.sv
// Packet-aware N:1 write arbiter between ingress buffers and the SRAM write
// path. A port is granted at a packet boundary and keeps the grant from SOP
// to EOP; its beats are streamed into one registered output stage with
// valid/ready backpressure.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   sp0_wrr1, weight_p  : policy select and packed per-port WRR weights
//   ready/vld/sop/eop   : per-port packet-available, beat valid and framing
//   data_in_p           : packed per-port beat data
//   next_data           : one-hot pop strobe back to the granted port
//   out_vld/out_ready   : output handshake
//   out_sop/out_eop     : output beat framing
//   out_port            : source port of the output beat
//   selected_data_out   : output beat data
//   busy                : a packet is granted and not yet complete
//   pkt_cnt_p           : per-port 16-bit completed-packet counters, present
//                         only when WRR_ARB_STATS_EN is defined
module wrr_pkt_write_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 16,
  parameter int DATA_WIDTH    = 256,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sp0_wrr1,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight_p,
  input  logic [NUM_PORTS-1:0]              ready,
  input  logic [NUM_PORTS-1:0]              vld,
  input  logic [NUM_PORTS-1:0]              sop,
  input  logic [NUM_PORTS-1:0]              eop,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   data_in_p,
  output logic [NUM_PORTS-1:0]              next_data,
  output logic                              out_vld,
  input  logic                              out_ready,
  output logic                              out_sop,
  output logic                              out_eop,
  output logic [PORT_ID_WIDTH-1:0]          out_port,
  output logic [DATA_WIDTH-1:0]             selected_data_out,
`ifdef WRR_ARB_STATS_EN
  output logic [NUM_PORTS*16-1:0]           pkt_cnt_p,
`endif
  output logic                              busy
);

  arb_state_e               state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]     req;
  logic                     arb_en;
  logic                     gnt_valid;
  logic [PORT_ID_WIDTH-1:0] gnt_idx;
  logic                     pop;
  logic [DATA_WIDTH-1:0]    data_arr [NUM_PORTS];

  logic                     out_vld_q, out_vld_d;
  logic                     out_sop_q, out_sop_d;
  logic                     out_eop_q, out_eop_d;
  logic [PORT_ID_WIDTH-1:0] out_port_q, out_port_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;

  assign req    = ready & vld & sop;
  assign arb_en = (state_q == IDLE);

  wrr_arb_grant #(
    .NUM_PORTS     (NUM_PORTS),
    .WEIGHT_WIDTH  (WEIGHT_WIDTH),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_grant (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .sp0_wrr1  (sp0_wrr1),
    .weight_p  (weight_p),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Unpack the beat bus so the granted port can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      data_arr[i] = data_in_p[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A beat moves whenever the granted port has one and the output stage is
  // empty or draining this cycle. Gated by rst so no port is popped while
  // the arbiter is being reset.
  assign pop = (state_q == XFER) && vld[gnt_q] && (!out_vld_q || out_ready) && !rst;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // FSM next state: grant is latched at the packet boundary and held until
  // the EOP beat is popped.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = XFER;
          gnt_d   = gnt_idx;
        end
      end
      XFER: begin
        if (pop && eop[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    next_data = '0;
    if (pop) next_data[gnt_q] = 1'b1;
    busy = (state_q == XFER);
  end

  // Output stage: load on pop, hold under backpressure, empty once accepted.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_sop_d  = out_sop_q;
    out_eop_d  = out_eop_q;
    out_port_d = out_port_q;
    out_data_d = out_data_q;
    if (pop) begin
      out_vld_d  = 1'b1;
      out_sop_d  = sop[gnt_q];
      out_eop_d  = eop[gnt_q];
      out_port_d = gnt_q;
      out_data_d = data_arr[gnt_q];
    end else if (out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_port_q <= '0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_sop_q  <= out_sop_d;
      out_eop_q  <= out_eop_d;
      out_port_q <= out_port_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_vld           = out_vld_q;
  assign out_sop           = out_sop_q;
  assign out_eop           = out_eop_q;
  assign out_port          = out_port_q;
  assign selected_data_out = out_data_q;

`ifdef WRR_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_PORTS];
  logic [15:0] cnt_d [NUM_PORTS];

  // A packet counts as done when its EOP beat is accepted downstream.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (out_vld_q && out_ready && out_eop_q) begin
      cnt_d[out_port_q] = cnt_q[out_port_q] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_cnt_p[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_wrr_pkt_write_arbiter.sv
// Self-checking bench for wrr_pkt_write_arbiter. Ports are modelled as packet
// sources that advance on next_data; expected output beats are queued as
// packets are scheduled and popped as the DUT delivers them.
module tb_wrr_pkt_write_arbiter;

  localparam int NP = 16;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            sp0_wrr1;
  logic [NP*WW-1:0] weight_p;
  logic [NP-1:0]   ready, vld, sop, eop;
  logic [NP*DW-1:0] data_in_p;
  logic [NP-1:0]   next_data;
  logic            out_vld, out_ready, out_sop, out_eop, busy;
  logic [PW-1:0]   out_port;
  logic [DW-1:0]   selected_data_out;
`ifdef WRR_ARB_STATS_EN
  logic [NP*16-1:0] pkt_cnt_p;
`endif

  wrr_pkt_write_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .PORT_ID_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .weight_p(weight_p),
    .ready(ready), .vld(vld), .sop(sop), .eop(eop), .data_in_p(data_in_p),
    .next_data(next_data), .out_vld(out_vld), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
    .selected_data_out(selected_data_out),
`ifdef WRR_ARB_STATS_EN
    .pkt_cnt_p(pkt_cnt_p),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct {
    beat_t       beat;
    logic        vld;
    logic        acc;
    logic [NP-1:0] nd;
    logic        busy;
  } obs_t;

  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;
  beat_t exp_q[$];

  int pkt_left[NP];
  int pkt_len[NP];
  int beat_idx[NP];
  int pkt_num[NP];

  function automatic logic [DW-1:0] beat_data(input int p, input int n, input int b);
    return {8'(p), 8'(n), 8'(b), 8'hA5};
  endfunction

  // Drive every port from its source model state.
  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      ready[i] = (pkt_left[i] > 0);
      vld[i]   = (pkt_left[i] > 0);
      sop[i]   = (pkt_left[i] > 0) && (beat_idx[i] == 0);
      eop[i]   = (pkt_left[i] > 0) && (beat_idx[i] == pkt_len[i] - 1);
      data_in_p[i*DW +: DW] = (pkt_left[i] > 0) ? beat_data(i, pkt_num[i], beat_idx[i]) : '0;
    end
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) begin
      pkt_left[i] = 0; pkt_len[i] = 1; beat_idx[i] = 0; pkt_num[i] = 0;
    end
    exp_q.delete();
    drive_ports();
  endtask

  task automatic load_packets(input int p, input int count, input int len);
    pkt_left[p] = count; pkt_len[p] = len; beat_idx[p] = 0; pkt_num[p] = 0;
  endtask

  task automatic push_pkt(input int p, input int n, input int len);
    for (int b = 0; b < len; b++) begin
      exp_q.push_back('{port: PW'(p), data: beat_data(p, n, b),
                        sop: (b == 0), eop: (b == len - 1)});
    end
  endtask

  // One clock: sample outputs on the falling edge, then advance the sources
  // that were popped on the rising edge.
  task automatic step(output obs_t o);
    @(negedge clk);
    o.beat = '{port: out_port, data: selected_data_out, sop: out_sop, eop: out_eop};
    o.vld  = out_vld;
    o.acc  = out_vld & out_ready;
    o.nd   = next_data;
    o.busy = busy;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (o.nd[i] && pkt_left[i] > 0) begin
        beat_idx[i]++;
        if (beat_idx[i] == pkt_len[i]) begin
          beat_idx[i] = 0; pkt_num[i]++; pkt_left[i]--;
        end
      end
    end
    drive_ports();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    clear_sources();
    @(posedge clk);
    step(o);
    compared += 6;
    if (o.vld !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_vld: got %b want 0", o.vld); end
    if (o.beat !== '0) begin mismatched++; $display("[TB] FAIL reset_out_beat: got %h want 0", o.beat); end
    if (o.nd !== '0) begin mismatched++; $display("[TB] FAIL reset_next_data: got %h want 0", o.nd); end
    if (o.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", o.busy); end
    if (out_sop !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_sop: got %b want 0", out_sop); end
    if (out_port !== '0) begin mismatched++; $display("[TB] FAIL reset_out_port: got %0d want 0", out_port); end
    rst = 1'b0;
  endtask

  task automatic test_sp();
    obs_t o; beat_t e;
    sp0_wrr1 = 1'b0;
    do_reset();
    load_packets(9, 1, 2);
    load_packets(3, 1, 2);
    push_pkt(3, 0, 2);
    push_pkt(9, 0, 2);
    drive_ports();
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      step(o);
      if (o.acc) begin
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL sp_beat: got %h want %h", o.beat, e); end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL sp_timeout: got %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_wrr();
    obs_t o; beat_t e;
    int mc[NP]; int w[NP]; int left[NP]; int num[NP];
    int ml, win, first_acc, last_acc;
    bit any_el;
    sp0_wrr1 = 1'b1;
    weight_p = '0;
    weight_p[0*WW +: WW] = 4'd2;
    weight_p[1*WW +: WW] = 4'd1;
    do_reset();
    load_packets(0, 4, 2);
    load_packets(1, 2, 2);
    for (int i = 0; i < NP; i++) begin
      w[i] = (weight_p[i*WW +: WW] == 0) ? 1 : int'(weight_p[i*WW +: WW]);
      mc[i] = w[i]; left[i] = pkt_left[i]; num[i] = 0;
    end
    ml = NP - 1;
    for (int g = 0; g < 6; g++) begin
      any_el = 1'b0;
      for (int i = 0; i < NP; i++) if (left[i] > 0 && mc[i] > 0) any_el = 1'b1;
      if (!any_el) for (int i = 0; i < NP; i++) mc[i] = w[i];
      win = -1;
      for (int k = 1; k <= NP; k++) begin
        if (win < 0 && left[(ml + k) % NP] > 0 && mc[(ml + k) % NP] > 0) win = (ml + k) % NP;
      end
      mc[win]--; ml = win;
      push_pkt(win, num[win], 2);
      num[win]++; left[win]--;
    end
    drive_ports();
    first_acc = -1; last_acc = -1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      step(o);
      if (o.acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL wrr_beat: got %h want %h", o.beat, e); end
      end
    end
    compared += 2;
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL wrr_timeout: got %0d beats left want 0", exp_q.size()); end
    if (last_acc - first_acc + 1 != 17) begin
      mismatched++; $display("[TB] FAIL wrr_span: got %0d cycles want 17", last_acc - first_acc + 1);
    end
  endtask

  task automatic test_backpressure();
    obs_t o; beat_t e;
    int n_acc;
    sp0_wrr1 = 1'b0;
    do_reset();
    load_packets(2, 1, 4);
    push_pkt(2, 0, 4);
    drive_ports();
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      step(o);
      if (o.acc) begin
        n_acc++;
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL bp_beat: got %h want %h", o.beat, e); end
      end
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(o);
      compared += 3;
      if (o.vld !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_vld: got %b want 1", o.vld); end
      if (o.beat.data !== beat_data(2, 0, 2)) begin
        mismatched++; $display("[TB] FAIL bp_hold_data: got %h want %h", o.beat.data, beat_data(2, 0, 2));
      end
      if (o.nd !== '0) begin mismatched++; $display("[TB] FAIL bp_next_data: got %h want 0", o.nd); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(o);
      if (o.acc) begin
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL bp_beat: got %h want %h", o.beat, e); end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL bp_timeout: got %0d beats left want 0", exp_q.size()); end
    for (int c = 0; c < 4; c++) begin
      step(o);
      compared++;
      if (o.acc) begin mismatched++; $display("[TB] FAIL bp_extra_beat: got %h want none", o.beat); end
    end
  endtask

  task automatic test_single_wrap();
    obs_t o; beat_t e;
    int busy_cnt;
    sp0_wrr1 = 1'b1;
    weight_p = {NP{4'd1}};
    do_reset();
    load_packets(15, 1, 1);
    push_pkt(15, 0, 1);
    drive_ports();
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(o);
      if (o.busy) busy_cnt++;
      if (o.acc) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++; $display("[TB] FAIL wrap_beat: got %h want none", o.beat);
        end else begin
          e = exp_q.pop_front();
          if (o.beat !== e) begin mismatched++; $display("[TB] FAIL wrap_beat: got %h want %h", o.beat, e); end
        end
      end
    end
    compared += 2;
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL wrap_timeout: got %0d beats left want 0", exp_q.size()); end
    if (busy_cnt != 1) begin mismatched++; $display("[TB] FAIL wrap_busy_cycles: got %0d want 1", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    obs_t o; beat_t e;
    int n_acc;
    sp0_wrr1 = 1'b1;
    weight_p = {NP{4'd1}};
    do_reset();
    load_packets(7, 1, 4);
    push_pkt(7, 0, 4);
    drive_ports();
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 1; c++) begin
      step(o);
      if (o.acc) begin
        n_acc++;
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL rstmid_beat: got %h want %h", o.beat, e); end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    compared += 4;
    if (out_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_out_vld: got %b want 0", out_vld); end
    if ({out_sop, out_eop, out_port, selected_data_out} !== '0) begin
      mismatched++; $display("[TB] FAIL rstmid_out_fields: got %h want 0", {out_sop, out_eop, out_port, selected_data_out});
    end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_busy: got %b want 0", busy); end
    if (next_data !== '0) begin mismatched++; $display("[TB] FAIL rstmid_next_data: got %h want 0", next_data); end
    clear_sources();
    load_packets(7, 1, 2);
    load_packets(0, 1, 2);
    push_pkt(0, 0, 2);
    push_pkt(7, 0, 2);
    drive_ports();
    rst = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      step(o);
      if (o.acc) begin
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL rstmid_after_beat: got %h want %h", o.beat, e); end
      end
    end
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("[TB] FAIL rstmid_timeout: got %0d beats left want 0", exp_q.size()); end
  endtask

`ifdef WRR_ARB_STATS_EN
  task automatic test_stats();
    obs_t o; beat_t e;
    logic [NP*16-1:0] want;
    sp0_wrr1 = 1'b0;
    do_reset();
    load_packets(2, 5, 2);
    for (int n = 0; n < 5; n++) push_pkt(2, n, 2);
    drive_ports();
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      step(o);
      if (o.acc) begin
        e = exp_q.pop_front(); compared++;
        if (o.beat !== e) begin mismatched++; $display("[TB] FAIL stats_beat: got %h want %h", o.beat, e); end
      end
    end
    step(o);
    want = '0;
    want[47:32] = 16'd5;
    compared++;
    if (pkt_cnt_p !== want) begin mismatched++; $display("[TB] FAIL stats_cnt: got %h want %h", pkt_cnt_p, want); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    sp0_wrr1  = 1'b0;
    weight_p  = '0;
    out_ready = 1'b1;
    clear_sources();
    test_reset();
    test_sp();
    test_wrr();
    test_backpressure();
    test_single_wrap();
    test_reset_mid();
`ifdef WRR_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
